// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side adapter for a registered-output FIFO.
// Issues pops only when a buffer slot is guaranteed for every word in flight,
// captures returning words into a 3-entry circular buffer and presents them
// as a valid/ready stream with a periodic end-of-packet marker.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 64,
  parameter int PKT_LEN    = 16,
  parameter int CNT_W      = $clog2(PKT_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  flush,
  output logic                  fifo_pop,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [CNT_W-1:0]      pkt_cnt
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_LEN - 1);

  logic                  rd_pending_q, rd_pending_d;
  logic [1:0]            occ_q, occ_d;
  logic [1:0]            head_q, head_d;
  logic [1:0]            tail_q, tail_d;
  logic [CNT_W-1:0]      pkt_q, pkt_d;
  logic [DATA_WIDTH-1:0] mem_q [0:2];

  logic [2:0]            committed;
  logic                  accept;

  // Pointers walk 0,1,2 and wrap back to 0.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Slots already claimed: buffered words plus the word returning this cycle.
  assign committed = {1'b0, occ_q} + {2'b0, rd_pending_q};

  // Pop depends only on registers and FIFO status, never on m_ready.
  // reset_n gating keeps the FIFO untouched while the block is held in reset.
  assign fifo_pop = reset_n & enable & ~flush & ~fifo_empty & (committed <= 3'd2);

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = m_valid ? mem_q[head_q] : '0;
  assign m_last  = m_valid & (pkt_q == LAST_CNT);
  assign pkt_cnt = pkt_q;
  assign accept  = m_valid & m_ready;

  // Next-state for pointers, occupancy, pending flag and packet counter.
  always_comb begin
    rd_pending_d = fifo_pop;
    occ_d        = occ_q;
    head_d       = head_q;
    tail_d       = tail_q;
    pkt_d        = pkt_q;
    if (flush) begin
      // Flush drops buffered and in-flight words; a concurrent accept still
      // completes downstream but does not advance the packet position.
      rd_pending_d = 1'b0;
      occ_d        = 2'd0;
      head_d       = 2'd0;
      tail_d       = 2'd0;
      pkt_d        = '0;
    end else begin
      if (rd_pending_q) tail_d = ptr_inc(tail_q);
      if (accept)       head_d = ptr_inc(head_q);
      occ_d = occ_q + {1'b0, rd_pending_q} - {1'b0, accept};
      if (accept) pkt_d = m_last ? '0 : pkt_q + CNT_W'(1);
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pending_q <= 1'b0;
      occ_q        <= 2'd0;
      head_q       <= 2'd0;
      tail_q       <= 2'd0;
      pkt_q        <= '0;
    end else begin
      rd_pending_q <= rd_pending_d;
      occ_q        <= occ_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      pkt_q        <= pkt_d;
    end
  end

  // Buffer storage: capture the returning FIFO word at the tail slot.
  always_ff @(posedge clk) begin
    if (rd_pending_q && !flush) mem_q[tail_q] <= fifo_data_out;
  end

endmodule
